// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux through the enabled channels, dwelling on each
// before capturing mux_out; skipped channels take one cycle and read as 0.
module mux_scan_ctrl #(
   parameter int DWELL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] mask,
   input  logic       mux_out,
   output logic [1:0] select,
   output logic [3:0] sample,
   output logic       busy,
   output logic       done
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   localparam logic [7:0] LAST = 8'(DWELL - 1);
   state_t     state;
   logic [1:0] ch;
   logic [7:0] cnt;
   logic [3:0] msk;
   logic [3:0] shadow;
   logic       fin;
   logic       bit_val;
   always_comb begin
      fin     = !msk[ch] || cnt == LAST;
      bit_val = msk[ch] & mux_out;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ch     <= '0;
         cnt    <= '0;
         msk    <= '0;
         shadow <= '0;
         sample <= '0;
         select <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state  <= SCAN;
               msk    <= mask;
               ch     <= '0;
               cnt    <= '0;
               shadow <= '0;
               select <= '0;
               busy   <= 1'b1;
            end
            SCAN: if (fin) begin
               shadow[ch] <= bit_val;
               cnt        <= '0;
               // the last channel's bit is merged directly so sample is complete on this edge
               if (ch == 2'd3) begin
                  state  <= DONE;
                  sample <= {bit_val, shadow[2:0]};
                  select <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end else begin
                  ch     <= ch + 2'd1;
                  select <= ch + 2'd1;
               end
            end else begin
               cnt <= cnt + 8'd1;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for two scanner instances (DWELL=4 and DWELL=1)
// driving a modelled 4:1 mux.
module tb_mux_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       st[2];
   logic [3:0] mk[2];
   logic [3:0] dd[2];
   logic       mo[2];
   logic [1:0] sel[2];
   logic [3:0] smp[2];
   logic       bsy[2];
   logic       dn[2];
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         dcnt[2];
   logic [35:0] q0[$];
   logic [35:0] q1[$];
   logic [31:0] acc[2];
   logic [1:0]  lsel[2];
   logic        bad[2];
   logic        pdone[2];

   always #5 clk = ~clk;

   assign mo[0] = dd[0][sel[0]];
   assign mo[1] = dd[1][sel[1]];

   mux_scan_ctrl #(.DWELL(4)) dut4 (
      .clk(clk), .rst(rst), .start(st[0]), .mask(mk[0]), .mux_out(mo[0]),
      .select(sel[0]), .sample(smp[0]), .busy(bsy[0]), .done(dn[0])
   );
   mux_scan_ctrl #(.DWELL(1)) dut1 (
      .clk(clk), .rst(rst), .start(st[1]), .mask(mk[1]), .mux_out(mo[1]),
      .select(sel[1]), .sample(smp[1]), .busy(bsy[1]), .done(dn[1])
   );

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // expected {sample, per-channel cycle counts}: enabled channels dwell, others take one cycle
   function automatic logic [35:0] model(input int dw, input logic [3:0] m, input logic [3:0] d);
      logic [31:0] c;
      c = '0;
      for (int n = 0; n < 4; n++) c[n*8 +: 8] = m[n] ? 8'(dw) : 8'd1;
      return {m & d, c};
   endfunction

   function automatic int len_of(input int dw, input logic [3:0] m);
      int l;
      l = 0;
      for (int n = 0; n < 4; n++) l += m[n] ? dw : 1;
      return l;
   endfunction

   task automatic push(input int k, input logic [35:0] e);
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic mon(input int k, input logic rs, input logic b, input logic d,
                      input logic [1:0] s, input logic [3:0] sm);
      logic [35:0] e;
      if (rs) begin
         acc[k] = '0;
         lsel[k] = '0;
         bad[k] = 1'b0;
         pdone[k] = 1'b0;
      end else begin
         if (!b) chk($sformatf("idle_select%0d", k), 36'(s), 36'd0);
         if (b) begin
            if (s < lsel[k]) bad[k] = 1'b1;
            acc[k][{s, 3'b000} +: 8] = acc[k][{s, 3'b000} +: 8] + 8'd1;
            lsel[k] = s;
         end
         if (d) begin
            dcnt[k]++;
            chk($sformatf("done_single%0d", k), 36'(pdone[k]), 36'd0);
            chk($sformatf("done_not_busy%0d", k), 36'(b), 36'd0);
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
               chk($sformatf("unexpected_done%0d", k), 36'd1, 36'd0);
            end else begin
               e = (k == 0) ? q0.pop_front() : q1.pop_front();
               chk($sformatf("sample%0d", k), 36'(sm), 36'(e[35:32]));
               chk($sformatf("chan_cycles%0d", k), 36'(acc[k]), 36'(e[31:0]));
               chk($sformatf("select_order%0d", k), 36'(bad[k]), 36'd0);
            end
            acc[k] = '0;
            lsel[k] = '0;
            bad[k] = 1'b0;
         end
         pdone[k] = d;
      end
   endtask

   always @(negedge clk) begin
      mon(0, rst, bsy[0], dn[0], sel[0], smp[0]);
      mon(1, rst, bsy[1], dn[1], sel[1], smp[1]);
   end

   task automatic scan(input int k, input logic [3:0] m, input logic [3:0] d,
                       input int pulse_at, input int rst_at);
      int dw;
      int n;
      int bc;
      int len;
      int dc;
      dw = (k == 0) ? 4 : 1;
      len = len_of(dw, m);
      mk[k] = m;
      dd[k] = d;
      st[k] = 1'b1;
      push(k, model(dw, m, d));
      tick;
      st[k] = 1'b0;
      mk[k] = 4'($urandom);
      n = 1;
      bc = 0;
      while (!dn[k] && n <= 1100) begin
         if (n == rst_at) begin
            rst = 1'b1;
            q0.delete();
            q1.delete();
            dc = dcnt[k];
            tick;
            rst = 1'b0;
            chk("rst_select", 36'(sel[k]), 36'd0);
            chk("rst_busy", 36'(bsy[k]), 36'd0);
            chk("rst_sample", 36'(smp[k]), 36'd0);
            chk("rst_done", 36'(dn[k]), 36'd0);
            repeat (40) tick;
            chk("no_done_after_rst", 36'(dcnt[k]), 36'(dc));
            return;
         end
         bc += int'(bsy[k]);
         st[k] = (n == pulse_at);
         tick;
         n++;
      end
      st[k] = 1'b0;
      chk("scan_len", 36'(bc), 36'(len));
      chk("done_cycle", 36'(n), 36'(len + 1));
      tick;
   endtask

   initial begin
      int tprev;
      int n;
      logic [3:0] dseq[3];
      for (int k = 0; k < 2; k++) begin
         st[k] = 1'b0;
         mk[k] = 4'hf;
         dd[k] = 4'h0;
         dcnt[k] = 0;
      end
      repeat (2) tick;
      for (int k = 0; k < 2; k++) begin
         chk("reset_select", 36'(sel[k]), 36'd0);
         chk("reset_sample", 36'(smp[k]), 36'd0);
         chk("reset_busy", 36'(bsy[k]), 36'd0);
         chk("reset_done", 36'(dn[k]), 36'd0);
      end
      rst = 1'b0;
      scan(0, 4'b1111, 4'b1010, -1, -1);
      scan(0, 4'b0101, 4'b1010, -1, -1);
      scan(0, 4'b0101, 4'b1111, -1, -1);
      scan(0, 4'b1111, 4'b0110, 5, -1);
      scan(0, 4'b1111, 4'b1010, -1, 8);
      scan(0, 4'b1111, 4'b1100, -1, -1);
      dseq[0] = 4'b1010;
      dseq[1] = 4'b0101;
      dseq[2] = 4'b1111;
      mk[0] = 4'hf;
      dd[0] = dseq[0];
      st[0] = 1'b1;
      push(0, model(4, 4'hf, dseq[0]));
      tprev = 0;
      for (int i = 0; i < 3; i++) begin
         n = 0;
         while (!dn[0] && n < 100) begin
            tick;
            n++;
         end
         chk("b2b_done_seen", 36'(dn[0]), 36'd1);
         if (i > 0) chk("b2b_period", 36'(cyc - tprev), 36'd18);
         tprev = cyc;
         if (i < 2) begin
            dd[0] = dseq[i+1];
            push(0, model(4, 4'hf, dseq[i+1]));
         end else begin
            st[0] = 1'b0;
         end
         tick;
      end
      tick;
      scan(1, 4'b1111, 4'b1010, -1, -1);
      scan(1, 4'b0000, 4'b1111, -1, -1);
      scan(0, 4'b0000, 4'b1111, -1, -1);
      for (int i = 0; i < 30; i++) begin
         scan(int'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
              $urandom_range(0, 1) ? int'($urandom_range(1, 14)) : -1, -1);
      end
      repeat (3) tick;
      chk("queues_drained", 36'(q0.size() + q1.size()), 36'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
